// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser and centre-of-bit sampling.
// Optional even-parity (8E1) support is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT = BIT_TIME / 2;
    localparam int unsigned CNT_W    = 16;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_busy_q, rx_busy_d;
    logic               frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic               par_bit_q, par_bit_d;
    logic               parity_err_q, parity_err_d;
`endif

    // State, datapath and registered outputs; synchroniser flops reset to idle-high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_busy_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_busy_q    <= rx_busy_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic: counter clears on every transition and every bit sample
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s_q;
                    state_d   = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bit_q != (^shift_q)) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end
`else
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        rx_busy_d = (state_d != IDLE);
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

    localparam int unsigned BT = 10;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned LAT_EXP = 108;
`else
    localparam int unsigned LAT_EXP = 98;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    int n_cmp;
    int n_bad;
    int cyc;
    int t_fall;
    int t_valid;
    int n_ferr;
    int n_perr;
    int n_multi;
    logic busy_seen;
    logic [7:0] rx_log[$];

    uart_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log.push_back(rx_data);
            t_valid = cyc;
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (parity_err) n_perr = n_perr + 1;
        if ((int'(rx_valid) + int'(frame_err) + int'(parity_err)) > 1) n_multi = n_multi + 1;
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) begin end
`endif
        drive_bit(stop);
    endtask

    int nv;
    int lat;

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; n_ferr = 0; n_perr = 0; n_multi = 0;
        t_fall = 0; t_valid = 0; busy_seen = 1'b0;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data",  32'(rx_data),    32'h00);
        check_eq("rst_valid", 32'(rx_valid),   32'h0);
        check_eq("rst_busy",  32'(rx_busy),    32'h0);
        check_eq("rst_ferr",  32'(frame_err),  32'h0);
        check_eq("rst_perr",  32'(parity_err), 32'h0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single 0x55 frame
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("b55_count", 32'(rx_log.size()), 32'd1);
        check_eq("b55_data",  32'(rx_data), 32'h55);
        check_eq("b55_ferr",  32'(n_ferr), 32'd0);
        check_eq("b55_busy",  32'(rx_busy), 32'h0);
        lat = t_valid - t_fall;
        check_eq("b55_lat_ok", 32'((lat >= int'(LAT_EXP) - 1) && (lat <= int'(LAT_EXP) + 1)), 32'd1);

        // Back-to-back 0xA3 then 0x0F
        send_frame(8'hA3, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("b2b_count", 32'(rx_log.size()), 32'd3);
        if (rx_log.size() >= 3) begin
            check_eq("b2b_first",  32'(rx_log[1]), 32'hA3);
            check_eq("b2b_second", 32'(rx_log[2]), 32'h0F);
        end
        check_eq("b2b_data", 32'(rx_data), 32'h0F);

        // Start-bit glitch of 3 cycles
        nv = rx_log.size();
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check_eq("glitch_novalid", 32'(rx_log.size()), 32'(nv));
        check_eq("glitch_noferr",  32'(n_ferr), 32'd0);
        check_eq("glitch_idle",    32'(rx_busy), 32'h0);

        // Stop bit low, line held low 50 cycles
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("brk_ferr",    32'(n_ferr), 32'd1);
        check_eq("brk_data",    32'(rx_data), 32'h0F);
        check_eq("brk_busy",    32'(rx_busy), 32'h1);
        check_eq("brk_novalid", 32'(rx_log.size()), 32'(nv));
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("brk_idle",      32'(rx_busy), 32'h0);
        check_eq("brk_nospur",    32'(rx_log.size()), 32'(nv));
        check_eq("brk_ferr_once", 32'(n_ferr), 32'd1);

        // Reset during data bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_data",  32'(rx_data),  32'h00);
        check_eq("mid_rst_busy",  32'(rx_busy),  32'h0);
        check_eq("mid_rst_valid", 32'(rx_valid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("mid_rst_discard", 32'(rx_log.size()), 32'(nv));
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("post_rst_count", 32'(rx_log.size()), 32'(nv + 1));
        check_eq("post_rst_data",  32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so the even-parity bit must be 1
        nv = rx_log.size();
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("par_bad_perr",    32'(n_perr), 32'd1);
        check_eq("par_bad_novalid", 32'(rx_log.size()), 32'(nv));
        check_eq("par_bad_data",    32'(rx_data), 32'h81);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("par_ok_count", 32'(rx_log.size()), 32'(nv + 1));
        check_eq("par_ok_data",  32'(rx_data), 32'h07);
        check_eq("par_ok_perr",  32'(n_perr), 32'd1);
`else
        check_eq("perr_never", 32'(n_perr), 32'd0);
`endif

        check_eq("strobe_mutex", 32'(n_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
